fdivsqrt_issue: RTL and testbench

Request-side controller for the iterative divide/square-root unit: accepts integer divide/remainder requests from the execute pipeline, queues them, launches each on the divider with a one-cycle start pulse, waits for done, and returns the tagged result to writeback over a valid/ready handshake. It sits between the pipeline issue logic and the divider's start/busy/done interface. It decouples pipeline stalls from the multi-cycle divider latency.

---
 rtl/fdivsqrt_issue.sv | 169 ++++++++++++++++
 tb/tb_fdivsqrt_issue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_issue.sv
// Request-side controller for the iterative divide/sqrt unit: queues requests, launches the divider, returns tagged results.
// Optional watchdog abort is compiled in with FDIVSQRT_ISSUE_WATCHDOG_EN.
module fdivsqrt_issue #(
    parameter int XLEN    = 64,
    parameter int TAGW    = 5,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 127
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [XLEN-1:0] ReqA,
    input  logic [XLEN-1:0] ReqB,
    input  logic [2:0]      ReqOp,
    input  logic            ReqW64,
    input  logic [TAGW-1:0] ReqTag,
    input  logic            FlushE,
    output logic            DivStart,
    output logic [XLEN-1:0] DivA,
    output logic [XLEN-1:0] DivB,
    output logic [2:0]      DivOp,
    output logic            DivW64,
    output logic            DivAbort,
    input  logic            DivBusy,
    input  logic            DivDone,
    input  logic [XLEN-1:0] DivResult,
    output logic            RspValid,
    input  logic            RspReady,
    output logic [XLEN-1:0] RspData,
    output logic [TAGW-1:0] RspTag,
    output logic            RspErr,
    output logic            Idle
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_a   [DEPTH];
    logic [XLEN-1:0] r_b   [DEPTH];
    logic [2:0]      r_op  [DEPTH];
    logic            r_w64 [DEPTH];
    logic [TAGW-1:0] r_tag [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_rsp_data;
    logic [TAGW-1:0] r_rsp_tag;
    logic            r_rsp_err;
    logic            w_ready;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_expire;

    assign w_ready = (r_count != CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A flush also swallows any push presented in the same cycle.
    assign w_push  = ReqValid && w_ready && !FlushE;
    assign w_pop   = (r_state == S_WAIT) && (DivDone || w_expire) && !FlushE;

`ifdef FDIVSQRT_ISSUE_WATCHDOG_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WDW-1:0] r_wd;

    // r_wd holds (WAIT cycles elapsed - 1), so expiry lands on the TIMEOUT-th WAIT cycle.
    assign w_expire = (r_state == S_WAIT) && !DivDone && (r_wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_wd <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd <= r_wd + WDW'(1);
        end
    end
    assign RspErr = r_rsp_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_expire = 1'b0;
    assign RspErr   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_op[i]  <= '0;
                r_w64[i] <= 1'b0;
                r_tag[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (FlushE) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_a[r_wptr]   <= ReqA;
                r_b[r_wptr]   <= ReqB;
                r_op[r_wptr]  <= ReqOp;
                r_w64[r_wptr] <= ReqW64;
                r_tag[r_wptr] <= ReqTag;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_pop) begin
            r_rsp_data <= w_expire ? '0 : DivResult;
            r_rsp_tag  <= r_tag[r_rptr];
            r_rsp_err  <= w_expire;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty && !DivBusy) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (DivDone || w_expire) w_next = S_HOLD;
            S_HOLD:   if (RspReady) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (FlushE) w_next = S_IDLE;
    end

    assign ReqReady = w_ready;
    assign DivStart = (r_state == S_LAUNCH) && !FlushE;
    assign DivAbort = (FlushE && ((r_state == S_LAUNCH) || (r_state == S_WAIT))) || (w_expire && !FlushE);
    assign DivA     = r_a[r_rptr];
    assign DivB     = r_b[r_rptr];
    assign DivOp    = r_op[r_rptr];
    assign DivW64   = r_w64[r_rptr];
    assign RspValid = (r_state == S_HOLD);
    assign RspData  = r_rsp_data;
    assign RspTag   = r_rsp_tag;
    assign Idle     = w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_fdivsqrt_issue.sv
// Directed self-checking bench for fdivsqrt_issue (default parameters).
module tb_fdivsqrt_issue;
    logic        clk;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [63:0] ReqA;
    logic [63:0] ReqB;
    logic [2:0]  ReqOp;
    logic        ReqW64;
    logic [4:0]  ReqTag;
    logic        FlushE;
    logic        DivStart;
    logic [63:0] DivA;
    logic [63:0] DivB;
    logic [2:0]  DivOp;
    logic        DivW64;
    logic        DivAbort;
    logic        DivBusy;
    logic        DivDone;
    logic [63:0] DivResult;
    logic        RspValid;
    logic        RspReady;
    logic [63:0] RspData;
    logic [4:0]  RspTag;
    logic        RspErr;
    logic        Idle;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    fdivsqrt_issue #(.XLEN(64), .TAGW(5), .DEPTH(2), .TIMEOUT(127)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqA(ReqA), .ReqB(ReqB),
        .ReqOp(ReqOp), .ReqW64(ReqW64), .ReqTag(ReqTag), .FlushE(FlushE),
        .DivStart(DivStart), .DivA(DivA), .DivB(DivB), .DivOp(DivOp), .DivW64(DivW64),
        .DivAbort(DivAbort), .DivBusy(DivBusy), .DivDone(DivDone), .DivResult(DivResult),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspTag(RspTag),
        .RspErr(RspErr), .Idle(Idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [4:0] tag);
        ReqValid = 1'b1;
        ReqA     = a;
        ReqB     = a + 64'd1;
        ReqOp    = 3'b100;
        ReqTag   = tag;
    endtask

    // Waits for the launch, returns the result one cycle into WAIT, holds it for 'hold' cycles, then hands off.
    task automatic run_op(input logic [63:0] res, input logic [4:0] etag, input logic [63:0] ea,
                          input int hold, output int l);
        l = 0;
        while (!DivStart && l < 50) begin
            step();
            l++;
        end
        chk("launch", DivStart, 1'b1);
        chk("launch_a", DivA, ea);
        step();
        chk("wait_nostart", DivStart, 1'b0);
        chk("wait_noabort", DivAbort, 1'b0);
        DivDone   = 1'b1;
        DivResult = res;
        step();
        DivDone = 1'b0;
        #1;
        chk("rsp_valid", RspValid, 1'b1);
        chk("rsp_data", RspData, res);
        chk("rsp_tag", RspTag, etag);
        chk("rsp_err", RspErr, 1'b0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", RspValid, 1'b1);
            chk("hold_data", RspData, res);
            chk("hold_tag", RspTag, etag);
            chk("hold_nostart", DivStart, 1'b0);
        end
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        #1;
        chk("handoff", RspValid, 1'b0);
    endtask

    initial begin
        reset = 1'b0; ReqValid = 1'b0; ReqA = '0; ReqB = '0; ReqOp = '0; ReqW64 = 1'b0;
        ReqTag = '0; FlushE = 1'b0; DivBusy = 1'b0; DivDone = 1'b0; DivResult = '0; RspReady = 1'b0;
        #3;
        chk("rst_reqready", ReqReady, 1'b1);
        chk("rst_divstart", DivStart, 1'b0);
        chk("rst_divabort", DivAbort, 1'b0);
        chk("rst_rspvalid", RspValid, 1'b0);
        chk("rst_rspdata", RspData, 64'd0);
        chk("rst_rsptag", RspTag, 5'd0);
        chk("rst_rsperr", RspErr, 1'b0);
        chk("rst_idle", Idle, 1'b1);
        chk("rst_diva", DivA, 64'd0);
        #10 reset = 1'b1;
        step();

        // Single op: accept at edge N, DivStart in cycle N+2, DivDone 20 cycles later with 14.
        ReqValid = 1'b1; ReqA = 64'd100; ReqB = 64'd7; ReqOp = 3'b100; ReqTag = 5'd3;
        #1;
        chk("t1_ready", ReqReady, 1'b1);
        step();
        ReqValid = 1'b0;
        #1;
        chk("t1_n1_nostart", DivStart, 1'b0);
        chk("t1_n1_idle", Idle, 1'b0);
        chk("t1_diva", DivA, 64'd100);
        step();
        chk("t1_n2_start", DivStart, 1'b1);
        chk("t1_divb", DivB, 64'd7);
        chk("t1_divop", DivOp, 3'b100);
        for (int i = 0; i < 20; i++) step();
        chk("t1_wait_norsp", RspValid, 1'b0);
        DivDone = 1'b1; DivResult = 64'd14;
        step();
        DivDone = 1'b0;
        #1;
        chk("t1_rspvalid", RspValid, 1'b1);
        chk("t1_rspdata", RspData, 64'd14);
        chk("t1_rsptag", RspTag, 5'd3);
        chk("t1_rsperr", RspErr, 1'b0);
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        #1;
        chk("t1_done_valid", RspValid, 1'b0);
        chk("t1_done_idle", Idle, 1'b1);

        // Back-pressure: third push refused until the first pop, then results in order.
        push(64'd10, 5'd1);
        #1;
        chk("t2_ready1", ReqReady, 1'b1);
        step();
        push(64'd20, 5'd2);
        #1;
        chk("t2_ready2", ReqReady, 1'b1);
        step();
        push(64'd30, 5'd3);
        #1;
        chk("t2_full", ReqReady, 1'b0);
        chk("t2_start", DivStart, 1'b1);
        chk("t2_diva", DivA, 64'd10);
        step();
        chk("t2_full_wait", ReqReady, 1'b0);
        DivDone = 1'b1; DivResult = 64'h11;
        #1;
        chk("t2_full_popcycle", ReqReady, 1'b0);
        step();
        DivDone = 1'b0;
        #1;
        chk("t2_ready_after_pop", ReqReady, 1'b1);
        chk("t2_rspvalid1", RspValid, 1'b1);
        chk("t2_rsptag1", RspTag, 5'd1);
        chk("t2_rspdata1", RspData, 64'h11);
        RspReady = 1'b1;
        step();
        ReqValid = 1'b0; RspReady = 1'b0;
        #1;
        chk("t2_handoff1", RspValid, 1'b0);
        chk("t2_full_again", ReqReady, 1'b0);
        run_op(64'h22, 5'd2, 64'd20, 10, lat);
        chk("t2_lat2", lat, 1);
        run_op(64'h33, 5'd3, 64'd30, 0, lat);
        chk("t2_lat3", lat, 1);
        chk("t2_idle", Idle, 1'b1);

        // Busy gating: no launch while the divider reports busy.
        DivBusy = 1'b1;
        push(64'd70, 5'd7);
        step();
        ReqValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_busy_nostart", DivStart, 1'b0);
        end
        DivBusy = 1'b0;
        #1;
        run_op(64'h77, 5'd7, 64'd70, 0, lat);
        chk("t3_lat", lat, 1);

        // Flush in WAIT with two entries queued.
        push(64'd80, 5'd8);
        step();
        push(64'd90, 5'd9);
        step();
        ReqValid = 1'b0;
        #1;
        chk("t4_start", DivStart, 1'b1);
        step();
        FlushE = 1'b1;
        #1;
        chk("t4_abort", DivAbort, 1'b1);
        step();
        FlushE = 1'b0;
        #1;
        chk("t4_idle", Idle, 1'b1);
        chk("t4_abort_off", DivAbort, 1'b0);
        chk("t4_norsp", RspValid, 1'b0);
        chk("t4_ready", ReqReady, 1'b1);
        step();
        DivDone = 1'b1; DivResult = 64'h99;
        step();
        DivDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_late_done_norsp", RspValid, 1'b0);
            chk("t4_late_nostart", DivStart, 1'b0);
        end
        chk("t4_still_idle", Idle, 1'b1);

`ifdef FDIVSQRT_ISSUE_WATCHDOG_EN
        // Watchdog: no DivDone, abort lands on the 127th WAIT cycle.
        push(64'd5, 5'd12);
        step();
        ReqValid = 1'b0;
        lat = 0;
        while (!DivStart && lat < 50) begin
            step();
            lat++;
        end
        chk("t5_start", DivStart, 1'b1);
        step();
        lat = 1;
        while (!DivAbort && lat < 200) begin
            step();
            lat++;
        end
        chk("t5_abort_cycle", lat, 127);
        step();
        chk("t5_rspvalid", RspValid, 1'b1);
        chk("t5_rsperr", RspErr, 1'b1);
        chk("t5_rspdata", RspData, 64'd0);
        chk("t5_rsptag", RspTag, 5'd12);
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        #1;
        chk("t5_idle", Idle, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
